fft_frame_seq: RTL
==================

# fft_frame_seq

Parametrised frame sequencer that sits between the pin-level I/O controller and the FFT engine.
- Accepts N complex samples over a valid/ready stream and presents them to the engine as a flattened frame.
- Starts the engine with a start/done handshake and captures its results.
- Streams the bins back out, narrowed to a configurable output width, under valid/ready backpressure.
- Generalises the fixed 4-point, nibble-output loader/readout to any power-of-two point count, data width and output width, and adds abort and backpressure support.

## Interface
- N_POINTS, 4, number of complex points per frame; power of two, ≥2
- DATA_W, 8, signed width of each real/imag component, both in and out of the engine
- OUT_W, 4, signed width of each streamed component; 1 ≤ OUT_W ≤ DATA_W
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  asynchronous reset, active-high
- ena  in  1  clock enable; when low, all state is frozen and no handshake completes
- abort  in  1  synchronous flush back to LOAD
- in_valid  in  1  sample offered
- in_ready  out  1  sample accepted when in_valid && in_ready
- in_data  in  2*DATA_W  {real, imag}, signed
- eng_start  out  1  one-cycle start pulse to the engine
- eng_done  in  1  engine results valid, single-cycle pulse
- eng_in  out  N_POINTS*2*DATA_W  sample buffer; sample k at bits [(k+1)*2*DATA_W-1 : k*2*DATA_W]
- eng_out  in  N_POINTS*2*DATA_W  engine results, same packing as eng_in
- out_valid  out  1  bin available
- out_ready  in  1  bin consumed when out_valid && out_ready
- out_data  out  2*OUT_W  {real, imag} narrowed
- out_index  out  $clog2(N_POINTS)  bin number of out_data
- out_last  out  1  high with the final bin of a frame
- state  out  2  current state, for the display controller

## Operation
- States and their encodings: LOAD=0, START=1, WAIT=2, STREAM=3.
- **LOAD**
  - in_ready = ena && (state==LOAD).
  - Each accept writes in_data to sample[wr_ptr] and increments wr_ptr.
  - The accept with wr_ptr==N_POINTS-1 clears wr_ptr and goes to START.
- **START**
  - eng_start=1 for exactly one cycle, then go to WAIT.
- **WAIT**
  - eng_done captures all of eng_out into the result buffer, clears rd_ptr and goes to STREAM.
- **STREAM**
  - out_valid=1, out_index=rd_ptr, out_last=(rd_ptr==N_POINTS-1).
  - out_data = narrow(result[rd_ptr]).
  - A transfer increments rd_ptr; the last transfer clears rd_ptr and goes to LOAD.
- eng_in is the registered sample buffer and is held stable from the START cycle until the next LOAD accept.
- **Narrowing (default):** arithmetic truncation to the top OUT_W bits of each component. When OUT_W==DATA_W the value passes through unchanged.
- **Boundary rules**
  - abort has priority over every other event: state goes to LOAD, wr_ptr and rd_ptr are cleared, eng_start is forced low, and buffer contents are left as they are.
  - An engine that is mid-computation when abort is asserted is not cancelled. Its later eng_done is ignored.
  - eng_done outside WAIT is ignored.
  - in_valid outside LOAD is ignored.
  - eng_done and abort in the same cycle: abort wins and no capture occurs.
  - ena low: no pointer, buffer or state change, and in_ready=0. out_valid and out_data hold their values. A transfer does not count while ena is low.
  - The pointers wrap only through the explicit clears described above, never by overflow.

## Timing
- **Reset values:** state=LOAD, in_ready=1 (if ena=1), eng_start=0, out_valid=0, out_last=0, out_index=0, out_data=0. eng_in and all buffers are 0.
- **Load throughput:** 1 sample/cycle.
- **Output throughput:** 1 bin/cycle while out_ready is held high.
- **Latency through START:** the last sample is accepted in cycle k, eng_start is high in cycle k+1, and state=WAIT from cycle k+2.
- **Latency to output:** eng_done in cycle m gives out_valid=1 with out_index=0 in cycle m+1.
- **Minimum frame time:** N_POINTS + 2 + engine latency + N_POINTS cycles.
- **Backpressure:** out_data, out_index and out_last are stable while out_valid && !out_ready.
- **Handshake outputs:** in_ready, out_valid and out_last are decoded from registered state only, with no combinational path from in_valid or out_ready. out_data is combinational from the registered buffer and rd_ptr.

## Configuration
- **FFT_ROUND_EN defined:** narrowing rounds half-up, then saturates.
  - Each component is computed as x + 2^(DATA_W-OUT_W-1).
  - The result is shifted right arithmetically by DATA_W-OUT_W.
  - It is then clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - The adder is one bit wider than DATA_W.
  - This path has no effect when OUT_W==DATA_W.
- **FFT_ROUND_EN not defined:** plain truncation; no adder or clamp logic is generated.

## Test plan
All scenarios use N_POINTS=4, DATA_W=8, OUT_W=4, and an engine model that asserts eng_done 3 cycles after eng_start and computes the exact DFT.
- **Impulse:** load (64,0),(0,0),(0,0),(0,0) → eng_start one cycle after the 4th accept; then 4 bins with out_data=8'h40, out_index=0..3, and out_last only on index 3.
- **Rounding:** engine bin real=56 (0x38), imag=-8 → without FFT_ROUND_EN out_data=8'h3F; with FFT_ROUND_EN out_data=8'h40. Real=127 with FFT_ROUND_EN saturates to nibble 7.
- **Backpressure:** hold out_ready low for 3 cycles while out_index=1 → out_data/out_index/out_last unchanged for all 3 cycles, and bin 2 follows one cycle after out_ready rises.
- **Abort mid-load:** accept 2 samples, then pulse abort → state=0, and the next 4 accepts form a new frame with eng_in sample0 equal to the 3rd sample sent.
- **Spurious/simultaneous events:** eng_done pulsed in LOAD → no state change. eng_done and abort together in WAIT → state=LOAD and out_valid stays 0.
- **Enable gating:** drop ena for 5 cycles in STREAM → out_index frozen even with out_ready=1, and streaming resumes at the same index. Assert rst mid-WAIT → all outputs return to their reset values immediately.

Source files
------------

// File: rtl/fft_frame_seq_if.sv
// Stream, engine and readout signals of the FFT frame sequencer.
// master: the sequencer side; slave: the I/O controller / engine side.
interface fft_frame_seq_if #(
    parameter int unsigned N_POINTS = 4,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned OUT_W    = 4
);
    localparam int unsigned IDX_W = $clog2(N_POINTS);

    logic                         in_valid;
    logic                         in_ready;
    logic [2*DATA_W-1:0]          in_data;
    logic                         eng_start;
    logic                         eng_done;
    logic [N_POINTS*2*DATA_W-1:0] eng_in;
    logic [N_POINTS*2*DATA_W-1:0] eng_out;
    logic                         out_valid;
    logic                         out_ready;
    logic [2*OUT_W-1:0]           out_data;
    logic [IDX_W-1:0]             out_index;
    logic                         out_last;

    modport master (
        input  in_valid, in_data, eng_done, eng_out, out_ready,
        output in_ready, eng_start, eng_in, out_valid, out_data, out_index, out_last
    );

    modport slave (
        output in_valid, in_data, eng_done, eng_out, out_ready,
        input  in_ready, eng_start, eng_in, out_valid, out_data, out_index, out_last
    );
endinterface

// File: rtl/fft_frame_seq.sv
// Frame sequencer: loads N complex samples, runs the FFT engine, streams narrowed bins.
// Optional FFT_ROUND_EN: round half-up and saturate when narrowing instead of truncating.
module fft_frame_seq #(
    parameter int unsigned N_POINTS = 4,
    parameter int unsigned DATA_W   = 8,
    parameter int unsigned OUT_W    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ena,
    input  logic                  abort,
    output logic [1:0]            state,
    fft_frame_seq_if.master       bus
);
    localparam int unsigned IDX_W = $clog2(N_POINTS);
    localparam int unsigned SMP_W = 2 * DATA_W;
    localparam int unsigned SH    = DATA_W - OUT_W;

    localparam logic [1:0] S_LOAD   = 2'd0;
    localparam logic [1:0] S_START  = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;
    localparam logic [1:0] S_STREAM = 2'd3;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_POINTS - 1);

    logic [1:0]       state_q, state_nx;
    logic [IDX_W-1:0] wr_ptr, wr_nx;
    logic [IDX_W-1:0] rd_ptr, rd_nx;
    logic             wr_en, cap_en;

    logic [SMP_W-1:0] samp_buf [N_POINTS];
    logic [SMP_W-1:0] res_buf  [N_POINTS];
    logic [N_POINTS*SMP_W-1:0] eng_in_flat;
    logic [SMP_W-1:0]          cur_bin;
    logic [2*OUT_W-1:0]        nar;

    // Next-state, pointer and buffer-enable decode; ena low freezes everything.
    always_comb begin
        state_nx = state_q;
        wr_nx    = wr_ptr;
        rd_nx    = rd_ptr;
        wr_en    = 1'b0;
        cap_en   = 1'b0;
        if (ena) begin
            if (abort) begin
                state_nx = S_LOAD;
                wr_nx    = '0;
                rd_nx    = '0;
            end else begin
                case (state_q)
                    S_LOAD: begin
                        if (bus.in_valid) begin
                            wr_en = 1'b1;
                            if (wr_ptr == LAST_IDX) begin
                                wr_nx    = '0;
                                state_nx = S_START;
                            end else begin
                                wr_nx = wr_ptr + IDX_W'(1);
                            end
                        end
                    end
                    S_START: state_nx = S_WAIT;
                    S_WAIT: begin
                        if (bus.eng_done) begin
                            cap_en   = 1'b1;
                            rd_nx    = '0;
                            state_nx = S_STREAM;
                        end
                    end
                    S_STREAM: begin
                        if (bus.out_ready) begin
                            if (rd_ptr == LAST_IDX) begin
                                rd_nx    = '0;
                                state_nx = S_LOAD;
                            end else begin
                                rd_nx = rd_ptr + IDX_W'(1);
                            end
                        end
                    end
                    default: state_nx = S_LOAD;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_LOAD;
            wr_ptr  <= '0;
            rd_ptr  <= '0;
        end else begin
            state_q <= state_nx;
            wr_ptr  <= wr_nx;
            rd_ptr  <= rd_nx;
        end
    end

    // Sample and result buffers; left untouched by abort.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < N_POINTS; k++) begin
                samp_buf[k] <= '0;
                res_buf[k]  <= '0;
            end
        end else begin
            if (wr_en) begin
                samp_buf[wr_ptr] <= bus.in_data;
            end
            if (cap_en) begin
                for (int k = 0; k < N_POINTS; k++) begin
                    res_buf[k] <= bus.eng_out[k*SMP_W +: SMP_W];
                end
            end
        end
    end

    always_comb begin
        eng_in_flat = '0;
        for (int k = 0; k < N_POINTS; k++) begin
            eng_in_flat[k*SMP_W +: SMP_W] = samp_buf[k];
        end
    end

    assign cur_bin = res_buf[rd_ptr];

    // Per-component narrowing; c=0 is imag (low half), c=1 is real.
    for (genvar c = 0; c < 2; c++) begin : g_comp
        logic signed [DATA_W-1:0] x;
        assign x = cur_bin[c*DATA_W +: DATA_W];
        if (SH == 0) begin : g_pass
            assign nar[c*OUT_W +: OUT_W] = x;
        end else begin : g_narrow
`ifdef FFT_ROUND_EN
            localparam logic signed [DATA_W:0] HALF = (DATA_W+1)'(1 << (SH - 1));
            localparam logic signed [DATA_W:0] MAXV = (DATA_W+1)'((1 << (OUT_W - 1)) - 1);
            localparam logic signed [DATA_W:0] MINV = ~MAXV;
            logic signed [DATA_W:0] sum;
            logic signed [DATA_W:0] shr;
            assign sum = {x[DATA_W-1], x} + HALF;
            assign shr = sum >>> SH;
            assign nar[c*OUT_W +: OUT_W] = (shr > MAXV) ? MAXV[OUT_W-1:0] :
                                           (shr < MINV) ? MINV[OUT_W-1:0] :
                                                          shr[OUT_W-1:0];
`else
            logic unused_lsbs;
            assign unused_lsbs = ^x[SH-1:0];
            assign nar[c*OUT_W +: OUT_W] = x[DATA_W-1 -: OUT_W];
`endif
        end
    end

    assign state         = state_q;
    assign bus.in_ready  = ena && (state_q == S_LOAD);
    assign bus.eng_start = ena && !abort && (state_q == S_START);
    assign bus.eng_in    = eng_in_flat;
    assign bus.out_valid = (state_q == S_STREAM);
    assign bus.out_index = rd_ptr;
    assign bus.out_last  = (state_q == S_STREAM) && (rd_ptr == LAST_IDX);
    assign bus.out_data  = nar;
endmodule
